uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rr_pick.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 85 ++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter.
package uart_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE} state_t;
    localparam int UART_BYTE_W     = 8;
    localparam int TIMEOUT_CYC_DEF = 65535;
    localparam int GRANT_W         = 3;
endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, searching ptr+1 .. ptr modulo NUM_REQ.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GRANT_W-1:0] i_ptr,
    output logic [GRANT_W-1:0] o_idx,
    output logic               o_any
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    always_comb begin
        int j;
        j = 0;
        o_idx = i_ptr;
        // Walk from farthest to nearest so the nearest set bit after ptr wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[IW'(j)]) o_idx = GRANT_W'(j);
        end
    end
    assign o_any = |i_req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between NUM_REQ byte sources.
// Define UART_ARB_TIMEOUT_EN to add a watchdog that aborts a frame after TIMEOUT_CYC cycles.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_BYTE_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic [GRANT_W-1:0]             grant_id,
    output logic                           arb_busy,
    output logic                           timeout_err
);
    state_t                 r_state;
    state_t                 w_next;
    logic [GRANT_W-1:0]     r_ptr;
    logic [GRANT_W-1:0]     r_gid;
    logic [UART_BYTE_W-1:0] r_data;
    logic [GRANT_W-1:0]     w_idx;
    logic                   w_any;
    logic                   w_grant;
    logic                   w_wait;
    logic                   w_to;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_grant = (r_state == S_IDLE) && w_any && !tx_busy;
    assign w_wait  = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_cnt <= '0;
        else if (w_grant) r_cnt <= '0;
        else if (w_wait)  r_cnt <= r_cnt + 16'd1;
    end
    // Fires on the TIMEOUT_CYC-th cycle after LAUNCH.
    assign w_to = w_wait && (r_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign w_to = 1'b0;
`endif

    always_comb begin
        w_next = w_to                       ? S_IDLE :
                 (r_state == S_IDLE)        ? (w_grant ? S_LAUNCH : S_IDLE) :
                 (r_state == S_LAUNCH)      ? S_WAIT_BUSY :
                 (r_state == S_WAIT_BUSY)   ? (tx_busy ? S_WAIT_DONE : S_WAIT_BUSY) :
                                              (tx_busy ? S_WAIT_DONE : S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= GRANT_W'(NUM_REQ - 1);
            r_gid   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_ptr  <= w_idx;
                r_gid  <= w_idx;
                r_data <= req_data[UART_BYTE_W*int'(w_idx) +: UART_BYTE_W];
            end
        end
    end

    assign tx_start    = (r_state == S_LAUNCH);
    assign req_ready   = tx_start ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_gid) : '0;
    assign tx_data     = r_data;
    assign grant_id    = r_gid;
    assign arb_busy    = (r_state != S_IDLE);
    assign timeout_err = w_to;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic [2:0]     grant_id;
    logic           arb_busy;
    logic           timeout_err;

    logic force_busy = 1'b0;
    logic model_en   = 1'b1;
    int   busy_len   = 20;
    int   bcnt       = 0;
    int   checks     = 0;
    int   errors     = 0;
    int   to_seen    = 0;

    typedef struct {
        logic [2:0] gid;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy from the cycle after tx_start for busy_len cycles.
    always @(posedge clk) begin
        if (tx_start && model_en) bcnt <= busy_len;
        else if (bcnt > 0)        bcnt <= bcnt - 1;
    end
    assign tx_busy = force_busy | (bcnt != 0);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int g, input int d);
        exp_t e;
        e.gid  = 3'(g);
        e.data = 8'(d);
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic v, input int d);
        req_valid[i]       = v;
        req_data[8*i +: 8] = 8'(d);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((arb_busy || tx_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", int'(arb_busy || tx_busy), 0);
    endtask

    task automatic wait_starts(input int k);
        int got = 0;
        int n = 0;
        while (got < k && n < 1000) begin
            @(negedge clk);
            n++;
            if (tx_start) got++;
        end
        chk("start_wait", got, k);
    endtask

    always @(negedge clk) begin
        if (timeout_err) to_seen++;
        if (!rst && (tx_start || req_ready != '0)) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", int'(req_ready), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tx_start", int'(tx_start), 1);
                chk("tx_data", int'(tx_data), int'(e.data));
                chk("grant_id", int'(grant_id), int'(e.gid));
                chk("req_ready", int'(req_ready), 1 << e.gid);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_arb_busy", int'(arb_busy), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        rst = 1'b0;

        // Single request, one cycle grant-to-start.
        @(negedge clk);
        set_req(2, 1'b1, 8'h5A);
        push(2, 8'h5A);
        @(negedge clk);
        chk("single_latency", int'(tx_start), 1);
        set_req(2, 1'b0, 0);
        wait_idle();

        // All four pending from reset: strict rotation 0,1,2,3,0.
        rst = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'hA0 + i);
        push(0, 8'hA0); push(1, 8'hA1); push(2, 8'hA2); push(3, 8'hA3); push(0, 8'hA0);
        @(negedge clk);
        chk("rst_hold_busy", int'(arb_busy), 0);
        rst = 1'b0;
        wait_starts(5);
        req_valid = '0;
        wait_idle();

        // tx_busy high in IDLE blocks grants.
        force_busy = 1'b1;
        set_req(1, 1'b1, 8'hB1);
        push(1, 8'hB1);
        begin
            int s = 0;
            repeat (6) begin
                @(negedge clk);
                if (tx_start) s++;
            end
            chk("blocked_start", s, 0);
        end
        force_busy = 1'b0;
        @(negedge clk);
        chk("unblock_latency", int'(tx_start), 1);
        set_req(1, 1'b0, 0);
        wait_idle();

        // Reset during WAIT_DONE.
        set_req(3, 1'b1, 8'h3C);
        push(3, 8'h3C);
        wait_starts(1);
        set_req(3, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("in_wait_done", int'(arb_busy && tx_busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_start", int'(tx_start), 0);
        chk("mid_rst_tx_data", int'(tx_data), 0);
        chk("mid_rst_req_ready", int'(req_ready), 0);
        chk("mid_rst_grant_id", int'(grant_id), 0);
        chk("mid_rst_arb_busy", int'(arb_busy), 0);
        chk("mid_rst_timeout", int'(timeout_err), 0);
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 8'hC0);
        set_req(3, 1'b1, 8'hC3);
        push(0, 8'hC0);
        push(3, 8'hC3);
        wait_starts(1);
        set_req(0, 1'b0, 0);
        wait_starts(1);
        set_req(3, 1'b0, 0);
        wait_idle();

        // Withdrawal: requester 3 would win but drops just before the grant.
        set_req(2, 1'b1, 8'h22);
        push(2, 8'h22);
        wait_starts(1);
        set_req(2, 1'b0, 0);
        wait_idle();
        force_busy = 1'b1;
        set_req(1, 1'b1, 8'h11);
        set_req(3, 1'b1, 8'h33);
        repeat (3) @(negedge clk);
        set_req(3, 1'b0, 0);
        force_busy = 1'b0;
        push(1, 8'h11);
        @(negedge clk);
        chk("withdraw_grant", int'(tx_start), 1);
        set_req(1, 1'b0, 0);
        wait_idle();
        repeat (10) @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
        // Transmitter never goes busy: watchdog aborts and rotation continues.
        model_en = 1'b0;
        set_req(2, 1'b1, 8'h77);
        set_req(0, 1'b1, 8'h70);
        push(2, 8'h77);
        push(0, 8'h70);
        wait_starts(1);
        set_req(2, 1'b0, 0);
        begin
            int n = 0;
            while (!timeout_err && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_cycles", n, 10);
        end
        @(negedge clk);
        chk("timeout_idle", int'(arb_busy), 0);
        wait_starts(1);
        set_req(0, 1'b0, 0);
        begin
            int n = 0;
            while (!timeout_err && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_second", n, 10);
        end
        wait_idle();
        model_en = 1'b1;
`else
        chk("timeout_never", to_seen, 0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
